// File: rtl/div_seq_ctrl.sv
// Sequencer for an iterative divider datapath: latches operands, steps the
// datapath index, captures the result and holds it until acknowledged.
module div_seq_ctrl #(
    parameter int STEPS = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] d_in,
    input  logic [32:0] f_in,
    input  logic        res_ack,
    input  logic [10:0] dp_rez,
    input  logic [32:0] dp_r,
    output logic        busy,
    output logic        res_valid,
    output logic        div_err,
    output logic [10:0] quot,
    output logic [32:0] rem_out,
    output logic [31:0] dp_D,
    output logic [32:0] dp_f,
    output logic [3:0]  dp_i,
    output logic        dp_rst
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_e;

    localparam logic [3:0] LAST = 4'(STEPS - 1);

    state_e      state_q, state_d;
    logic [31:0] dp_d_q, dp_d_d;
    logic [32:0] dp_f_q, dp_f_d;
    logic [3:0]  dp_i_q, dp_i_d;
    logic [10:0] quot_q, quot_d;
    logic [32:0] rem_q, rem_d;
    logic        err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dp_d_q  <= '0;
            dp_f_q  <= '0;
            dp_i_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dp_d_q  <= dp_d_d;
            dp_f_q  <= dp_f_d;
            dp_i_q  <= dp_i_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dp_d_d  = dp_d_q;
        dp_f_d  = dp_f_q;
        dp_i_d  = 4'd0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (f_in != '0) begin
                        dp_d_d  = d_in;
                        dp_f_d  = f_in;
                        state_d = LOAD;
                    end else begin
                        // zero divisor skips the datapath entirely
                        err_d   = 1'b1;
                        quot_d  = '0;
                        rem_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            LOAD: begin
                state_d = abort ? IDLE : RUN;
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dp_i_q == LAST) begin
                    quot_d  = dp_rez;
                    rem_d   = dp_r;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    dp_i_d = dp_i_q + 4'd1;
                end
            end
            DONE: begin
                if (res_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign res_valid = (state_q == DONE);
    assign div_err   = err_q && (state_q == DONE);
    assign dp_rst    = (state_q == IDLE) || (state_q == LOAD);
    assign quot      = quot_q;
    assign rem_out   = rem_q;
    assign dp_D      = dp_d_q;
    assign dp_f      = dp_f_q;
    assign dp_i      = dp_i_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomized checks of div_seq_ctrl against a
// transaction-level model of operand latching, timing and results.
module tb_div_seq_ctrl;

    localparam int STEPS = 11;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] d_in;
    logic [32:0] f_in;
    logic        res_ack;
    logic [10:0] dp_rez;
    logic [32:0] dp_r;
    logic        busy;
    logic        res_valid;
    logic        div_err;
    logic [10:0] quot;
    logic [32:0] rem_out;
    logic [31:0] dp_D;
    logic [32:0] dp_f;
    logic [3:0]  dp_i;
    logic        dp_rst;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q;
    logic [32:0] exp_r;
    logic        exp_err;
    logic [31:0] m_d;
    logic [32:0] m_f;

    div_seq_ctrl #(.STEPS(STEPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .d_in     (d_in),
        .f_in     (f_in),
        .res_ack  (res_ack),
        .dp_rez   (dp_rez),
        .dp_r     (dp_r),
        .busy     (busy),
        .res_valid(res_valid),
        .div_err  (div_err),
        .quot     (quot),
        .rem_out  (rem_out),
        .dp_D     (dp_D),
        .dp_f     (dp_f),
        .dp_i     (dp_i),
        .dp_rst   (dp_rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".valid"}, 64'(res_valid), 64'd0);
        chk({tag, ".err"}, 64'(div_err), 64'd0);
        chk({tag, ".dp_i"}, 64'(dp_i), 64'd0);
        chk({tag, ".dp_rst"}, 64'(dp_rst), 64'd1);
        chk({tag, ".quot"}, 64'(quot), 64'(exp_q));
        chk({tag, ".rem"}, 64'(rem_out), 64'(exp_r));
        chk({tag, ".dp_D"}, 64'(dp_D), 64'(m_d));
        chk({tag, ".dp_f"}, 64'(dp_f), 64'(m_f));
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".valid"}, 64'(res_valid), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".err"}, 64'(div_err), 64'(exp_err));
        chk({tag, ".quot"}, 64'(quot), 64'(exp_q));
        chk({tag, ".rem"}, 64'(rem_out), 64'(exp_r));
        chk({tag, ".dp_i"}, 64'(dp_i), 64'd0);
        chk({tag, ".dp_rst"}, 64'(dp_rst), 64'd0);
    endtask

    // One operation: start edge, LOAD, STEPS RUN edges, then DONE hold and ack.
    // abort_at >= 0 aborts while dp_i equals it; keep_start leaves start high.
    task automatic do_op(input logic [31:0] d, input logic [32:0] f,
                         input int abort_at, input int ack_wait,
                         input bit keep_start);
        logic [10:0] rez;
        logic [32:0] r;
        bit aborted;
        aborted = 0;
        rez = '0;
        r = '0;
        d_in = d;
        f_in = f;
        start = 1'b1;
        tick();
        if (!keep_start) start = 1'b0;
        if (f == '0) begin
            exp_q = '0;
            exp_r = '0;
            exp_err = 1'b1;
            chk_done("zero");
            chk("zero.dp_f", 64'(dp_f), 64'(m_f));
        end else begin
            m_d = d;
            m_f = f;
            chk("load.busy", 64'(busy), 64'd1);
            chk("load.dp_rst", 64'(dp_rst), 64'd1);
            chk("load.dp_i", 64'(dp_i), 64'd0);
            chk("load.dp_D", 64'(dp_D), 64'(m_d));
            chk("load.dp_f", 64'(dp_f), 64'(m_f));
            chk("load.valid", 64'(res_valid), 64'd0);
            tick();
            for (int j = 0; j < STEPS && !aborted; j++) begin
                chk("run.dp_i", 64'(dp_i), 64'(j));
                chk("run.busy", 64'(busy), 64'd1);
                chk("run.dp_rst", 64'(dp_rst), 64'd0);
                chk("run.valid", 64'(res_valid), 64'd0);
                chk("run.dp_D", 64'(dp_D), 64'(m_d));
                chk("run.quot", 64'(quot), 64'(exp_q));
                if (j == abort_at) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    aborted = 1;
                    chk_idle("abort");
                end else begin
                    rez = 11'($urandom);
                    r = {1'($urandom), 32'($urandom)};
                    dp_rez = rez;
                    dp_r = r;
                    d_in = $urandom;
                    f_in = {1'($urandom), 32'($urandom)};
                    tick();
                end
            end
            if (!aborted) begin
                exp_q = rez;
                exp_r = r;
                exp_err = 1'b0;
                chk_done("fin");
                chk("fin.dp_D", 64'(dp_D), 64'(m_d));
                chk("fin.dp_f", 64'(dp_f), 64'(m_f));
            end
        end
        if (!aborted) begin
            for (int k = 0; k < ack_wait; k++) begin
                start = 1'b1;
                abort = 1'b1;
                dp_rez = 11'($urandom);
                dp_r = {1'($urandom), 32'($urandom)};
                tick();
                chk_done("hold");
            end
            start = keep_start;
            abort = 1'b0;
            res_ack = 1'b1;
            tick();
            res_ack = 1'b0;
            chk("ack.valid", 64'(res_valid), 64'd0);
            chk("ack.busy", 64'(busy), 64'd0);
            chk("ack.err", 64'(div_err), 64'd0);
            chk("ack.dp_rst", 64'(dp_rst), 64'd1);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        d_in = '0;
        f_in = '0;
        res_ack = 1'b0;
        dp_rez = '0;
        dp_r = '0;
        exp_q = '0;
        exp_r = '0;
        exp_err = 1'b0;
        m_d = '0;
        m_f = '0;
        #2 rst = 1'b0;
        #1;
        chk_idle("reset");
        tick();
        tick();
        rst = 1'b1;
        repeat (3) tick();
        chk_idle("post_reset");

        // idle ignores abort
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("idle_abort");

        // nominal operation followed by a long DONE hold
        do_op(32'd100, 33'd7, -1, 20, 0);
        chk_idle("after_op1");

        // zero divisor
        do_op(32'd55, 33'd0, -1, 2, 0);
        chk_idle("after_zero");

        // abort mid-RUN keeps the earlier result
        do_op(32'd100, 33'd7, -1, 0, 0);
        do_op(32'd1234, 33'd9, 5, 0, 0);
        repeat (2) tick();
        chk_idle("after_abort");

        // start held through a whole operation and the ack
        do_op(32'd77, 33'd5, -1, 3, 1);
        d_in = 32'd55;
        f_in = 33'd3;
        tick();
        start = 1'b0;
        m_d = 32'd55;
        m_f = 33'd3;
        chk("restart.busy", 64'(busy), 64'd1);
        chk("restart.dp_D", 64'(dp_D), 64'd55);
        chk("restart.dp_rst", 64'(dp_rst), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("load_abort");

        // asynchronous reset while dp_i = 7
        d_in = 32'd900;
        f_in = 33'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        repeat (7) tick();
        chk("pre_rst.dp_i", 64'(dp_i), 64'd7);
        #2 rst = 1'b0;
        #1;
        exp_q = '0;
        exp_r = '0;
        m_d = '0;
        m_f = '0;
        chk_idle("async_rst");
        #1 rst = 1'b1;
        repeat (4) tick();
        chk_idle("rst_release");

        // randomized operations
        for (int n = 0; n < 12; n++) begin
            logic [32:0] f;
            int ab;
            f = ($urandom_range(0, 3) == 0) ? 33'd0
                : {1'($urandom), 32'($urandom)};
            ab = ($urandom_range(0, 2) == 0)
                ? int'($urandom_range(0, STEPS - 1)) : -1;
            do_op($urandom, f, ab, int'($urandom_range(0, 3)), 0);
            tick();
            chk_idle("rand_idle");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
